// File: rtl/mbinit_sb_tx_packetizer_pkg.sv
// Shared sideband message definitions for the MBINIT TX packetizer:
// message codes, MsgCode/MsgSubcode lookup, opcode and FSM state encoding.
package sb_msg_pkg;

    localparam logic [3:0] MSG_NONE             = 4'd0;
    localparam logic [3:0] REPAIRMB_START_REQ   = 4'd1;
    localparam logic [3:0] REPAIRMB_START_RESP  = 4'd2;
    localparam logic [3:0] REPAIRMB_END_REQ     = 4'd3;
    localparam logic [3:0] REPAIRMB_END_RESP    = 4'd4;
    localparam logic [3:0] REVERSALMB_INIT_REQ  = 4'd5;
    localparam logic [3:0] REVERSALMB_INIT_RESP = 4'd6;
    localparam logic [3:0] REVERSALMB_DONE_REQ  = 4'd7;
    localparam logic [3:0] REVERSALMB_DONE_RESP = 4'd8;

    localparam logic [4:0] SB_OPCODE = 5'h12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_GAP
    } tx_state_t;

    typedef struct packed {
        logic [7:0] msg_code;
        logic [7:0] msg_subcode;
    } msg_id_t;

    // Requests are A5, responses AA; unknown codes fall back to FF/FF.
    function automatic msg_id_t msg_lookup(input logic [3:0] code);
        msg_id_t id;
        case (code)
            REPAIRMB_START_REQ:   id = '{8'hA5, 8'h0C};
            REPAIRMB_START_RESP:  id = '{8'hAA, 8'h0C};
            REPAIRMB_END_REQ:     id = '{8'hA5, 8'h10};
            REPAIRMB_END_RESP:    id = '{8'hAA, 8'h10};
            REVERSALMB_INIT_REQ:  id = '{8'hA5, 8'h0E};
            REVERSALMB_INIT_RESP: id = '{8'hAA, 8'h0E};
            REVERSALMB_DONE_REQ:  id = '{8'hA5, 8'h0F};
            REVERSALMB_DONE_RESP: id = '{8'hAA, 8'h0F};
            default:              id = '{8'hFF, 8'hFF};
        endcase
        return id;
    endfunction

endpackage

// File: rtl/mbinit_sb_tx_packetizer_if.sv
// Controller-to-packetizer sideband TX interface: message request in,
// serial data and busy handshake out.
interface mbinit_sb_tx_packetizer_if;
    logic [3:0] i_TX_SbMessage;
    logic [2:0] i_msg_info;
    logic       i_tx_data_valid;
    logic       o_busy;
    logic       o_falling_edge_busy;
    logic       o_sb_data;
    logic       o_sb_clk_en;
    logic       o_overflow;

    modport master (
        output i_TX_SbMessage, i_msg_info, i_tx_data_valid,
        input  o_busy, o_falling_edge_busy, o_sb_data, o_sb_clk_en, o_overflow
    );

    modport slave (
        input  i_TX_SbMessage, i_msg_info, i_tx_data_valid,
        output o_busy, o_falling_edge_busy, o_sb_data, o_sb_clk_en, o_overflow
    );
endinterface

// File: rtl/mbinit_sb_tx_packetizer_sb_pkt_encoder.sv
// Combinational builder of the 64-bit message-without-data packet,
// including the CP parity bit over bits [61:0].
module sb_pkt_encoder
    import sb_msg_pkg::*;
(
    input  logic [3:0]  code,
    input  logic [2:0]  info,
    output logic [63:0] packet
);

    msg_id_t     id;
    logic [61:0] body;

    always_comb begin
        id            = msg_lookup(code);
        body          = '0;
        body[4:0]     = SB_OPCODE;
        body[21:14]   = id.msg_code;
        body[39:32]   = id.msg_subcode;
        body[42:40]   = info;
        packet        = {1'b0, ^body, body};
    end

endmodule

// File: rtl/mbinit_sb_tx_packetizer.sv
// Sideband TX packetizer: edge-detects controller requests, buffers one
// pending message and serializes each packet LSB-first followed by an idle gap.
module mbinit_sb_tx_packetizer
    import sb_msg_pkg::*;
#(
    parameter int GAP_CYCLES = 32,
    parameter int PKT_BITS   = 64
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    mbinit_sb_tx_packetizer_if.slave sb
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    tx_state_t           state;
    tx_state_t           next_state;
    logic [PKT_BITS-1:0] shreg;
    logic [5:0]          bit_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic                prev_valid;
    logic [3:0]          prev_code;
    logic                armed;
    logic                pend_full;
    logic [3:0]          pend_code;
    logic [2:0]          pend_info;
    logic                fe_pulse;
    logic                ovf_pulse;
    logic                new_req;
    logic                launch;
    logic                data_done;
    logic                gap_done;
    logic [3:0]          launch_code;
    logic [2:0]          launch_info;
    logic [63:0]         launch_pkt;

    // armed stays low after reset until valid is seen low, so a level held
    // through reset is never mistaken for a fresh request.
    assign new_req = armed && sb.i_tx_data_valid && (sb.i_TX_SbMessage != MSG_NONE)
                     && (!prev_valid || (sb.i_TX_SbMessage != prev_code));

    assign launch      = (state == ST_IDLE) && (pend_full || new_req);
    assign launch_code = pend_full ? pend_code : sb.i_TX_SbMessage;
    assign launch_info = pend_full ? pend_info : sb.i_msg_info;
    assign data_done   = (state == ST_DATA) && (bit_cnt == 6'(PKT_BITS - 1));
    assign gap_done    = (state == ST_GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    sb_pkt_encoder u_encoder (
        .code   (launch_code),
        .info   (launch_info),
        .packet (launch_pkt)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (launch)    next_state = ST_DATA;
            ST_DATA: if (data_done) next_state = ST_GAP;
            ST_GAP:  if (gap_done)  next_state = ST_IDLE;
            default:                next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        sb.o_busy              = (state != ST_IDLE);
        sb.o_sb_clk_en         = (state == ST_DATA);
        sb.o_sb_data           = (state == ST_DATA) && shreg[0];
        sb.o_falling_edge_busy = fe_pulse;
        sb.o_overflow          = ovf_pulse;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            prev_valid <= 1'b0;
            prev_code  <= '0;
            armed      <= 1'b0;
            pend_full  <= 1'b0;
            pend_code  <= '0;
            pend_info  <= '0;
            fe_pulse   <= 1'b0;
            ovf_pulse  <= 1'b0;
        end else begin
            prev_valid <= sb.i_tx_data_valid;
            prev_code  <= sb.i_TX_SbMessage;
            if (!sb.i_tx_data_valid) armed <= 1'b1;
            fe_pulse  <= gap_done;
            ovf_pulse <= 1'b0;

            case (state)
                ST_IDLE: if (launch) begin
                    shreg   <= launch_pkt;
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 6'd1;
                end
                ST_GAP:  gap_cnt <= gap_done ? '0 : gap_cnt + 1'b1;
                default: ;
            endcase

            // In IDLE the pending entry launches first; a same-cycle request refills it.
            if (state == ST_IDLE) begin
                if (pend_full) begin
                    pend_full <= new_req;
                    if (new_req) begin
                        pend_code <= sb.i_TX_SbMessage;
                        pend_info <= sb.i_msg_info;
                    end
                end
            end else if (new_req) begin
                if (!pend_full) begin
                    pend_full <= 1'b1;
                    pend_code <= sb.i_TX_SbMessage;
                    pend_info <= sb.i_msg_info;
                end else begin
                    ovf_pulse <= 1'b1;
                end
            end
        end
    end

endmodule
